// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//
// Sequencing FSM for one cache set. Serves processor read/write hits in the
// request cycle; on a miss it writes back a dirty victim word by word, fills
// the line from memory, validates it and then serves the request as a hit.
//
// Optional feature macro: CACHE_PERF_COUNTER_EN
//   defined   -> adds hit_count_o / miss_count_o (32-bit wrapping counters)
//   undefined -> counters and ports are absent
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   read_i, write_i   processor requests (level, held until ready_o)
//   addr_i[31:0]      processor address
//   hit_i, dirty_i    set lookup result / dirty bit of selected line
//   tag_i             tag of the selected (victim) line
//   mem_ready_i       memory accepted write word / read data valid
//   control_o[5:0]    {write_en, update_en, set_valid, set_dirty,
//                      strategy_en, offset_sel} to the set
//   mem_addr_o[31:0]  word address to memory and the set
//   mem_read_o        memory read request
//   mem_write_o       memory write request
//   ready_o           one-cycle completion pulse
//   hit_count_o       (CACHE_PERF_COUNTER_EN) hit counter
//   miss_count_o      (CACHE_PERF_COUNTER_EN) miss counter
// -----------------------------------------------------------------------------
`ifndef CACHE_T
`define CACHE_T 24
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_controller #(
    parameter int TAG_WIDTH    = `CACHE_T,
    parameter int OFFSET_WIDTH = `CACHE_B
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [31:0]          addr_i,
    input  logic                 hit_i,
    input  logic                 dirty_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 mem_ready_i,
    output logic [5:0]           control_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 ready_o
`ifdef CACHE_PERF_COUNTER_EN
    ,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
`endif
);

    localparam int CW = OFFSET_WIDTH - 2;
    localparam int IW = 32 - TAG_WIDTH - OFFSET_WIDTH;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WRITE_BACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE   = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = '1;

    // control_o encodings
    localparam logic [5:0] CTRL_READ_HIT  = 6'b000011;
    localparam logic [5:0] CTRL_WRITE_HIT = 6'b101111;
    localparam logic [5:0] CTRL_FILL      = 6'b100000;
    localparam logic [5:0] CTRL_FILL_LAST = 6'b111000;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_next_state;
    logic [CW-1:0] w_next_cnt;
    logic          w_req;
    logic [IW-1:0] w_index;
    logic          w_cnt_last;

    logic          w_ready;
    logic [5:0]    w_ctrl;
    logic          w_mem_read;
    logic          w_mem_write;
    logic [31:0]   w_mem_addr;

    // Byte-offset bits are not needed: memory is addressed by word.
    logic          w_unused_offset;
    assign w_unused_offset = ^addr_i[OFFSET_WIDTH-1:0];

    assign w_req      = read_i | write_i;
    assign w_index    = addr_i[31-TAG_WIDTH:OFFSET_WIDTH];
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_ready      = 1'b0;
        w_ctrl       = '0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_addr   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (hit_i) begin
                        w_ready = 1'b1;
                        // simultaneous read and write is served as a write
                        w_ctrl  = write_i ? CTRL_WRITE_HIT : CTRL_READ_HIT;
                    end else begin
                        w_next_cnt   = '0;
                        w_next_state = dirty_i ? S_WRITE_BACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITE_BACK: begin
                // control stays 0: offset_sel=0 picks the victim word
                w_mem_write = 1'b1;
                w_mem_addr  = {tag_i, w_index, r_cnt, 2'b00};
                if (mem_ready_i) begin
                    w_next_cnt = r_cnt + 1'b1;  // wraps to 0 after last word
                    if (w_cnt_last) begin
                        w_next_state = S_ALLOCATE;
                    end
                end
            end
            S_ALLOCATE: begin
                w_mem_read = 1'b1;
                w_mem_addr = {addr_i[31:OFFSET_WIDTH], r_cnt, 2'b00};
                if (mem_ready_i) begin
                    w_next_cnt = r_cnt + 1'b1;
                    if (w_cnt_last) begin
                        w_ctrl       = CTRL_FILL_LAST;
                        w_next_state = S_IDLE;
                    end else begin
                        w_ctrl = CTRL_FILL;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Mealy outputs are forced low while reset is held, since IDLE would
    // otherwise reflect a pending hit.
    assign ready_o     = rst_i ? 1'b0 : w_ready;
    assign control_o   = rst_i ? '0   : w_ctrl;
    assign mem_read_o  = rst_i ? 1'b0 : w_mem_read;
    assign mem_write_o = rst_i ? 1'b0 : w_mem_write;
    assign mem_addr_o  = rst_i ? '0   : w_mem_addr;

`ifdef CACHE_PERF_COUNTER_EN
    logic        w_hit_evt;
    logic        w_miss_evt;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    assign w_hit_evt  = (r_state == S_IDLE) & w_req &  hit_i;
    assign w_miss_evt = (r_state == S_IDLE) & w_req & ~hit_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_evt)  r_hit_count  <= r_hit_count + 32'd1;
            if (w_miss_evt) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count_o  = r_hit_count;
    assign miss_count_o = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
//
// Self-checking bench for cache_controller (TAG_WIDTH=24, OFFSET_WIDTH=4,
// W=4). Each cycle's expected outputs are pushed to a scoreboard queue when
// the inputs are driven and popped and compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_cache_controller;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        hit_i = 1'b0;
    logic        dirty_i = 1'b0;
    logic [23:0] tag_i = '0;
    logic        mem_ready_i = 1'b0;
    logic [5:0]  control_o;
    logic [31:0] mem_addr_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        ready_o;
`ifdef CACHE_PERF_COUNTER_EN
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;
`endif

    cache_controller #(
        .TAG_WIDTH   (24),
        .OFFSET_WIDTH(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .read_i      (read_i),
        .write_i     (write_i),
        .addr_i      (addr_i),
        .hit_i       (hit_i),
        .dirty_i     (dirty_i),
        .tag_i       (tag_i),
        .mem_ready_i (mem_ready_i),
        .control_o   (control_o),
        .mem_addr_o  (mem_addr_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .ready_o     (ready_o)
`ifdef CACHE_PERF_COUNTER_EN
        ,
        .hit_count_o (hit_count_o),
        .miss_count_o(miss_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        ready;
        logic [5:0]  ctrl;
        logic        mrd;
        logic        mwr;
        logic [31:0] maddr;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        hit;
        logic        dirty;
        logic        mrdy;
        logic [31:0] addr;
        logic        ready;
        logic [5:0]  ctrl;
    } vec_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t mk(input logic r, input logic [5:0] c,
                                input logic rd, input logic wr,
                                input logic [31:0] a);
        exp_t e;
        e.ready = r;
        e.ctrl  = c;
        e.mrd   = rd;
        e.mwr   = wr;
        e.maddr = a;
        return e;
    endfunction

    task automatic check_out(input string nm);
        exp_t e;
        exp_t act;
        act = {ready_o, control_o, mem_read_o, mem_write_o, mem_addr_o};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, actual=%h", nm, act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: actual ready=%b ctrl=%b rd=%b wr=%b addr=%h, expected ready=%b ctrl=%b rd=%b wr=%b addr=%h",
                         nm, act.ready, act.ctrl, act.mrd, act.mwr, act.maddr,
                         e.ready, e.ctrl, e.mrd, e.mwr, e.maddr);
            end
        end
    endtask

    task automatic step(input string nm, input logic rst, input logic rd,
                        input logic wr, input logic hit, input logic dirty,
                        input logic mrdy, input logic [31:0] addr,
                        input logic [23:0] tag, input exp_t e);
        @(posedge clk_i);
        #1;
        rst_i       = rst;
        read_i      = rd;
        write_i     = wr;
        hit_i       = hit;
        dirty_i     = dirty;
        mem_ready_i = mrdy;
        addr_i      = addr;
        tag_i       = tag;
        sb_q.push_back(e);
        @(negedge clk_i);
        check_out(nm);
    endtask

    // Full miss: decide cycle, optional write-back (with nstall stall cycles
    // inserted before beat stall_beat), fill, then the hit that serves it.
    task automatic miss_seq(input string nm, input logic wr, input logic dirty,
                            input logic [31:0] addr, input logic [23:0] tag,
                            input int stall_beat, input int nstall,
                            input logic drop_req);
        logic [31:0] a;
        logic        rq;
        step({nm, "_decide"}, 0, ~wr, wr, 0, dirty, 1, addr, tag, '0);
        if (dirty) begin
            for (int b = 0; b < 4; b++) begin
                a = {tag, addr[7:4], 4'(b * 4)};
                if (b == stall_beat) begin
                    for (int s = 0; s < nstall; s++)
                        step({nm, "_wb_stall"}, 0, ~wr, wr, 0, dirty, 0, addr, tag,
                             mk(0, 6'b000000, 0, 1, a));
                end
                step({nm, "_wb"}, 0, ~wr, wr, 0, dirty, 1, addr, tag,
                     mk(0, 6'b000000, 0, 1, a));
            end
        end
        for (int b = 0; b < 4; b++) begin
            a  = {addr[31:4], 4'(b * 4)};
            rq = !(drop_req && b >= 1);
            step({nm, "_fill"}, 0, rq & ~wr, rq & wr, 0, dirty, 1, addr, tag,
                 mk(0, (b == 3) ? 6'b111000 : 6'b100000, 1, 0, a));
        end
        if (drop_req)
            step({nm, "_noready"}, 0, 0, 0, 1, 0, 1, addr, tag, '0);
        else
            step({nm, "_serve"}, 0, ~wr, wr, 1, 0, 0, addr, tag,
                 mk(1, wr ? 6'b101111 : 6'b000011, 0, 0, 32'h0));
    endtask

    vec_t vecs[7];

    initial begin
        //          rd wr hit dirty mrdy addr           ready ctrl
        vecs[0] = '{0, 0, 0, 1, 1, 32'h0000_1234, 0, 6'b000000};
        vecs[1] = '{0, 0, 1, 0, 0, 32'hDEAD_BEE0, 0, 6'b000000};
        vecs[2] = '{1, 0, 1, 0, 0, 32'h0000_1234, 1, 6'b000011};
        vecs[3] = '{0, 1, 1, 0, 0, 32'h0000_1234, 1, 6'b101111};
        vecs[4] = '{1, 1, 1, 0, 0, 32'h0000_5678, 1, 6'b101111};
        vecs[5] = '{1, 0, 1, 1, 1, 32'hFFFF_FFFC, 1, 6'b000011};
        vecs[6] = '{0, 1, 1, 1, 1, 32'h8000_0040, 1, 6'b101111};

        // reset: outputs low even with a pending hit
        step("reset_hold", 1, 1, 0, 1, 0, 1, 32'h0000_1234, 24'h0, '0);
        step("reset_release", 0, 0, 0, 0, 0, 0, 32'h0, 24'h0, '0);

        foreach (vecs[i])
            step($sformatf("vec%0d", i), 0, vecs[i].rd, vecs[i].wr, vecs[i].hit,
                 vecs[i].dirty, vecs[i].mrdy, vecs[i].addr, 24'h00ABCD,
                 mk(vecs[i].ready, vecs[i].ctrl, 0, 0, 32'h0));

        // clean read miss: ready at cycle 5
        miss_seq("clean_rd", 0, 0, 32'h0000_1234, 24'hABCDEF, -1, 0, 0);
        step("idle_after_clean", 0, 0, 0, 0, 0, 1, 32'h0, 24'h0, '0);

        // dirty read miss: ready at cycle 9
        miss_seq("dirty_rd", 0, 1, 32'h0000_1234, 24'h00ABCD, -1, 0, 0);

        // dirty write miss, 2 stall cycles after first write-back beat: cycle 11
        miss_seq("dirty_wr_stall", 1, 1, 32'h0000_1234, 24'h00ABCD, 1, 2, 0);

        // reset during ALLOCATE, then a fresh miss starting at cnt=0
        step("rst_mid_decide", 0, 1, 0, 0, 0, 1, 32'h0000_1234, 24'h0, '0);
        step("rst_mid_beat0", 0, 1, 0, 0, 0, 1, 32'h0000_1234, 24'h0,
             mk(0, 6'b100000, 1, 0, 32'h0000_1230));
        step("rst_mid_assert", 1, 1, 0, 0, 0, 1, 32'h0000_1234, 24'h0, '0);
        miss_seq("after_rst", 0, 0, 32'h0000_1234, 24'h0, -1, 0, 0);

        // request dropped during the fill: transfer completes, no ready
        miss_seq("drop", 0, 0, 32'h0000_ABC8, 24'h0, -1, 0, 1);

`ifdef CACHE_PERF_COUNTER_EN
        step("perf_rst", 1, 0, 0, 0, 0, 0, 32'h0, 24'h0, '0);
        for (int i = 0; i < 3; i++)
            step("perf_hit", 0, 1, 0, 1, 0, 0, 32'h0000_1234, 24'h0,
                 mk(1, 6'b000011, 0, 0, 32'h0));
        miss_seq("perf_miss", 0, 0, 32'h0000_2340, 24'h0, -1, 0, 0);
        step("perf_idle", 0, 0, 0, 0, 0, 0, 32'h0, 24'h0, '0);
        checks++;
        if (hit_count_o !== 32'd4) begin
            errors++;
            $display("FAIL hit_count: actual=%0d expected=4", hit_count_o);
        end
        checks++;
        if (miss_count_o !== 32'd1) begin
            errors++;
            $display("FAIL miss_count: actual=%0d expected=1", miss_count_o);
        end
`endif

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d entries left, expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
